fetch_unit: RTL and testbench

Parametrised instruction-fetch stage that owns the program counter. It drives a synchronous instruction memory with one-cycle read latency. It buffers returned words in a small prefetch queue and presents {pc, instruction, valid} to decode. It supports decode back-pressure (stall) and EX-stage branch redirects, discarding wrong-path fetches and pulsing a flush to downstream pipes.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_queue.sv | 74 +++++++
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// No logic of its own; the queue and top import it.
package fetch_pkg;

   localparam int FETCH_N = 32;

   localparam logic [FETCH_N-1:0] RESET_PC_DEFAULT = '0;

   typedef struct packed {
      logic [FETCH_N-1:0] pc;
      logic [FETCH_N-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, instr}: head visible combinationally, push-to-head one edge.
// Backpressure: pop only when non-empty; a push into a full queue is taken only alongside a pop.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int  DEPTH   = 2,
   parameter type entry_t = fetch_entry_t
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         clear_i,
   input  logic                         push_i,
   input  entry_t                       push_data_i,
   input  logic                         pop_i,
   output entry_t                       head_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [PW-1:0] LAST = PW'(DEPTH-1);

   entry_t          mem_q [DEPTH];
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            do_push, do_pop;

   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && ((count_q != FULL) || do_pop);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
         end
         if (do_push) begin
            wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: count_q alone decides what is valid.
   always_ff @(posedge CLK) begin
      if (!RST && !clear_i && do_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, reads a 1-cycle sync imem, queues words for decode (issue-to-valid 2 cycles).
// Backpressure: stall_i holds the head; issue stops once queued + in-flight words fill the queue.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int             N        = FETCH_N,
   parameter int             ADDR_W   = 12,
   parameter logic [N-1:0]   RESET_PC = N'(RESET_PC_DEFAULT),
   parameter int             QDEPTH   = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              stall_i,
   input  logic              redirect_i,
   input  logic [N-1:0]      redirect_target_i,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic              imem_en_o,
   input  logic [N-1:0]      imem_data_i,
   output logic [N-1:0]      instruction_o,
   output logic [N-1:0]      pc_o,
   output logic              valid_o,
   output logic              flush_o
);

   localparam int CW = $clog2(QDEPTH+1);
   localparam int OW = CW + 1;
   localparam logic [OW-1:0] QD = OW'(QDEPTH);

   typedef struct packed {
      logic [N-1:0] pc;
      logic [N-1:0] instr;
   } entry_t;

   logic [N-1:0]  fetch_pc_q, fetch_pc_d;
   logic          epoch_q, epoch_d;
   logic          inflight_q, inflight_d;
   logic [N-1:0]  req_pc_q, req_pc_d;
   logic          req_epoch_q, req_epoch_d;

   logic [CW-1:0] q_count;
   entry_t        q_head;
   entry_t        q_push_data;
   logic          q_push;
   logic          pop;
   logic          issue;
   logic [OW-1:0] occupancy;

   // Reserve a slot for the in-flight word so the queue can never overflow.
   assign valid_o   = ~RST & (q_count != '0);
   assign pop       = valid_o & ~stall_i;
   assign occupancy = {1'b0, q_count} + OW'(inflight_q) - OW'(pop);
   assign issue     = ~RST & ~redirect_i & (occupancy < QD);

   assign imem_en_o   = issue;
   assign imem_addr_o = fetch_pc_q[ADDR_W-1:0];
   assign flush_o     = redirect_i & ~RST;

   // Wrong-path words are recognised by a stale epoch or a same-cycle redirect.
   assign q_push           = inflight_q & (req_epoch_q == epoch_q) & ~redirect_i & ~RST;
   assign q_push_data.pc    = req_pc_q;
   assign q_push_data.instr = imem_data_i;

   always_comb begin
      fetch_pc_d  = fetch_pc_q;
      epoch_d     = epoch_q;
      inflight_d  = issue;
      req_pc_d    = req_pc_q;
      req_epoch_d = req_epoch_q;
      if (redirect_i) begin
         fetch_pc_d = redirect_target_i;
         epoch_d    = ~epoch_q;
      end else if (issue) begin
         fetch_pc_d  = fetch_pc_q + N'(1);
         req_pc_d    = fetch_pc_q;
         req_epoch_d = epoch_q;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         fetch_pc_q  <= RESET_PC;
         epoch_q     <= 1'b0;
         inflight_q  <= 1'b0;
         req_pc_q    <= '0;
         req_epoch_q <= 1'b0;
      end else begin
         fetch_pc_q  <= fetch_pc_d;
         epoch_q     <= epoch_d;
         inflight_q  <= inflight_d;
         req_pc_q    <= req_pc_d;
         req_epoch_q <= req_epoch_d;
      end
   end

   fetch_queue #(
      .DEPTH   (QDEPTH),
      .entry_t (entry_t)
   ) u_queue (
      .CLK         (CLK),
      .RST         (RST),
      .clear_i     (redirect_i),
      .push_i      (q_push),
      .push_data_i (q_push_data),
      .pop_i       (pop),
      .head_o      (q_head),
      .count_o     (q_count)
   );

   assign instruction_o = valid_o ? q_head.instr : '0;
   assign pc_o          = valid_o ? q_head.pc    : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Drives a 32-bit/depth-2 and an 8-bit/depth-4 fetch unit in lockstep against a
// transaction-level model (expected-PC queue, fetch PC, one in-flight slot).
module tb_fetch_unit;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        RST   = 1'b1;
   logic        stall = 1'b0;
   logic        redir = 1'b0;
   logic [31:0] tgt   = 32'd0;

   logic [11:0] addr0;
   logic        en0, valid0, flush0;
   logic [31:0] data0 = 32'd0;
   logic [31:0] instr0, pc0;

   logic [3:0]  addr1;
   logic        en1, valid1, flush1;
   logic [7:0]  data1 = 8'd0;
   logic [7:0]  instr1, pc1;

   fetch_unit #(.N(32), .ADDR_W(12), .RESET_PC(32'd0), .QDEPTH(2)) dut0 (
      .CLK(CLK), .RST(RST), .stall_i(stall), .redirect_i(redir),
      .redirect_target_i(tgt), .imem_addr_o(addr0), .imem_en_o(en0),
      .imem_data_i(data0), .instruction_o(instr0), .pc_o(pc0),
      .valid_o(valid0), .flush_o(flush0));

   fetch_unit #(.N(8), .ADDR_W(4), .RESET_PC(8'd254), .QDEPTH(4)) dut1 (
      .CLK(CLK), .RST(RST), .stall_i(stall), .redirect_i(redir),
      .redirect_target_i(tgt[7:0]), .imem_addr_o(addr1), .imem_en_o(en1),
      .imem_data_i(data1), .instruction_o(instr1), .pc_o(pc1),
      .valid_o(valid1), .flush_o(flush1));

   // Synchronous ROM: mem[a] = 0x1000 + a, truncated to the data width.
   always @(posedge CLK) begin
      if (en0) data0 <= 32'h1000 + {20'd0, addr0};
      if (en1) data1 <= 8'(32'h1000 + {28'd0, addr1});
   end

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] nmask [2];
   logic [31:0] amask [2];
   int          qdep  [2];
   logic [31:0] rpc   [2];

   logic [31:0] m_fpc    [2];
   bit          m_infl   [2];
   logic [31:0] m_inflpc [2];
   logic [31:0] m_q      [2][8];
   int          m_n      [2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_fpc[i]  = rpc[i];
         m_infl[i] = 1'b0;
         m_n[i]    = 0;
      end
   endtask

   task automatic step(input bit r, input bit s, input bit d, input logic [31:0] t);
      @(negedge CLK);
      RST = r; stall = s; redir = d; tgt = t;
      #1;
      for (int i = 0; i < 2; i++) begin
         logic [31:0] a_pc, a_ins, a_addr, e_pc, e_ins;
         bit a_v, a_en, a_fl, e_v, e_en, e_fl, popb;
         if (i == 0) begin
            a_pc = pc0; a_ins = instr0; a_addr = {20'd0, addr0};
            a_v = valid0; a_en = en0; a_fl = flush0;
         end else begin
            a_pc = {24'd0, pc1}; a_ins = {24'd0, instr1}; a_addr = {28'd0, addr1};
            a_v = valid1; a_en = en1; a_fl = flush1;
         end
         e_v   = !r && (m_n[i] > 0);
         e_pc  = e_v ? m_q[i][0] : 32'd0;
         e_ins = e_v ? ((32'h1000 + (e_pc & amask[i])) & nmask[i]) : 32'd0;
         popb  = e_v && !s;
         e_en  = !r && !d && ((m_n[i] + int'(m_infl[i]) - int'(popb)) < qdep[i]);
         e_fl  = !r && d;
         chk($sformatf("u%0d.valid", i), 32'(a_v), 32'(e_v));
         chk($sformatf("u%0d.pc", i), a_pc, e_pc);
         chk($sformatf("u%0d.instr", i), a_ins, e_ins);
         chk($sformatf("u%0d.imem_en", i), 32'(a_en), 32'(e_en));
         chk($sformatf("u%0d.flush", i), 32'(a_fl), 32'(e_fl));
         if (e_en) chk($sformatf("u%0d.imem_addr", i), a_addr, m_fpc[i] & amask[i]);

         if (r) begin
            m_fpc[i] = rpc[i]; m_n[i] = 0; m_infl[i] = 1'b0;
         end else begin
            if (popb) begin
               for (int k = 0; k < 7; k++) m_q[i][k] = m_q[i][k+1];
               m_n[i]--;
            end
            if (m_infl[i] && !d) begin
               if (m_n[i] >= qdep[i]) begin
                  chk($sformatf("u%0d.model_overflow", i), 32'(m_n[i]), 32'(qdep[i] - 1));
               end else begin
                  m_q[i][m_n[i]] = m_inflpc[i];
                  m_n[i]++;
               end
            end
            m_infl[i] = e_en;
            if (d) begin
               m_n[i]   = 0;
               m_fpc[i] = t & nmask[i];
            end else if (e_en) begin
               m_inflpc[i] = m_fpc[i];
               m_fpc[i]    = (m_fpc[i] + 32'd1) & nmask[i];
            end
         end
      end
   endtask

   task automatic do_reset();
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
   endtask

   int flushes;

   initial begin
      nmask[0] = 32'hFFFF_FFFF; nmask[1] = 32'h0000_00FF;
      amask[0] = 32'h0000_0FFF; amask[1] = 32'h0000_000F;
      qdep[0]  = 2;             qdep[1]  = 4;
      rpc[0]   = 32'd0;         rpc[1]   = 32'd254;
      model_reset();

      // Reset release, streaming, then a redirect to 12 in cycle 6.
      do_reset();
      step(0, 0, 0, 0);  // cycle 1
      chk("lit_c1_en0", 32'(en0), 32'd1);
      chk("lit_c1_addr0", {20'd0, addr0}, 32'd0);
      chk("lit_c1_addr1", {28'd0, addr1}, 32'hE);
      step(0, 0, 0, 0);  // cycle 2
      chk("lit_c2_valid0", 32'(valid0), 32'd0);
      step(0, 0, 0, 0);  // cycle 3
      chk("lit_c3_valid0", 32'(valid0), 32'd1);
      chk("lit_c3_pc0", pc0, 32'd0);
      chk("lit_c3_instr0", instr0, 32'h1000);
      chk("lit_c3_pc1", {24'd0, pc1}, 32'd254);
      step(0, 0, 0, 0);  // cycle 4
      chk("lit_c4_pc0", pc0, 32'd1);
      chk("lit_c4_instr0", instr0, 32'h1001);
      chk("lit_c4_pc1", {24'd0, pc1}, 32'd255);
      step(0, 0, 0, 0);  // cycle 5
      chk("lit_c5_pc1_wrap", {24'd0, pc1}, 32'd0);
      step(0, 0, 1, 32'd12);  // cycle 6
      chk("lit_c6_flush0", 32'(flush0), 32'd1);
      step(0, 0, 0, 0);  // cycle 7
      chk("lit_c7_valid0", 32'(valid0), 32'd0);
      step(0, 0, 0, 0);  // cycle 8
      chk("lit_c8_valid0", 32'(valid0), 32'd0);
      step(0, 0, 0, 0);  // cycle 9
      chk("lit_c9_pc0", pc0, 32'd12);
      chk("lit_c9_instr0", instr0, 32'h100C);

      // Stall in cycles 5-8.
      do_reset();
      for (int c = 1; c <= 12; c++) begin
         step(0, (c >= 5 && c <= 8), 0, 0);
         if (c >= 5 && c <= 9) chk($sformatf("lit_stall_c%0d_pc0", c), pc0, 32'd2);
         if (c == 5) chk("lit_stall_c5_en0", 32'(en0), 32'd0);
         if (c >= 10) chk($sformatf("lit_stall_c%0d_pc0", c), pc0, 32'(c - 7));
      end

      // Redirect under stall, then a second redirect to 40.
      do_reset();
      flushes = 0;
      for (int c = 1; c <= 12; c++) begin
         if (c == 5)      step(0, 1, 1, 32'd100);
         else if (c == 6) step(0, 0, 1, 32'd40);
         else             step(0, 0, 0, 0);
         if (flush0) flushes++;
         if (c == 7) chk("lit_rr_c7_addr0", {20'd0, addr0}, 32'd40);
         if (c == 8) chk("lit_rr_c8_valid0", 32'(valid0), 32'd0);
         if (c == 9) chk("lit_rr_c9_pc0", pc0, 32'd40);
         if (c == 10) chk("lit_rr_c10_pc0", pc0, 32'd41);
      end
      chk("lit_rr_flush_count", 32'(flushes), 32'd2);

      // Reset mid-stream, overriding a simultaneous redirect and stall.
      do_reset();
      for (int c = 1; c <= 6; c++) step(0, 0, 0, 0);
      step(1, 1, 1, 32'd77);  // cycle 7
      chk("lit_mr_valid0", 32'(valid0), 32'd0);
      chk("lit_mr_en0", 32'(en0), 32'd0);
      chk("lit_mr_flush0", 32'(flush0), 32'd0);
      step(0, 0, 0, 0);  // cycle 8
      chk("lit_mr_addr0", {20'd0, addr0}, 32'd0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);  // cycle 10
      chk("lit_mr_pc0", pc0, 32'd0);
      chk("lit_mr_pc1", {24'd0, pc1}, 32'd254);

      // Randomised traffic.
      for (int c = 0; c < 3000; c++) begin
         bit r, s, d;
         logic [31:0] t;
         r = ($urandom_range(0, 199) == 0);
         s = ($urandom_range(0, 99) < 30);
         d = ($urandom_range(0, 99) < 8);
         t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                           : 32'($urandom);
         step(r, s, d, t);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
